// File: rtl/pattern_bank_pkg.sv
// Shared types for the pattern bank: channel update modes and sequencer states.
package pattern_bank_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    CLEAR = 3'd1,
    ALT   = 3'd2,
    WALK  = 3'd3,
    COUNT = 3'd4,
    INV   = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pattern_lane.sv
// One channel of the pattern bank: a WIDTH-bit register that applies the
// selected update mode whenever upd is high.
module pattern_lane
  import pattern_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CH    = 0
) (
  input  logic             c,
  input  logic             rn,
  input  logic             clr,
  input  logic             upd,
  input  mode_e            mode,
  input  logic             phase,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] alt;
  logic [WIDTH-1:0] walk;
  logic [WIDTH-1:0] nxt;

  // Alternating pattern: bit j = (j + CH + phase) mod 2.
  for (genvar j = 0; j < WIDTH; j++) begin : g_alt
    assign alt[j] = phase ^ 1'((j + CH) % 2);
  end

  assign walk = (q == '0) ? WIDTH'(1) : {q[WIDTH-2:0], q[WIDTH-1]};

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves nxt
    // unassigned, which would otherwise infer a latch.
    nxt = q;
    case (mode)
      CLEAR:   nxt = '0;
      ALT:     nxt = alt;
      WALK:    nxt = walk;
      COUNT:   nxt = q + WIDTH'(1);
      INV:     nxt = ~q;
      default: nxt = q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of block ordering.
  always_ff @(posedge c or negedge rn) begin
    if (!rn)       q <= '0;
    else if (clr)  q <= '0;
    else if (upd)  q <= nxt;
  end

endmodule

// File: rtl/pattern_bank_gen.sv
// Bank of NCH pattern registers driven by a run sequencer: start latches a
// mode and length, the bank updates for len cycles, then done pulses once.
module pattern_bank_gen
  import pattern_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int LENW  = 8
) (
  input  logic                       c,
  input  logic                       rn,
  input  logic                       clr,
  input  logic                       start,
  input  logic [2:0]                 mode,
  input  logic [LENW-1:0]            len,
  input  logic [NCH-1:0]             en,
  output logic                       busy,
  output logic                       done,
  output logic [NCH-1:0][WIDTH-1:0]  a
);

  state_e          state;
  mode_e           mode_q;
  logic [LENW-1:0] cnt;
  logic            phase;

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state  <= IDLE;
      mode_q <= HOLD;
      cnt    <= '0;
      phase  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (clr) begin
      // Abort without a done pulse; the lanes clear themselves on clr.
      state  <= IDLE;
      cnt    <= '0;
      phase  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (len != '0) begin
              mode_q <= mode_e'(mode);
              cnt    <= len;
              phase  <= 1'b0;
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          cnt   <= cnt - LENW'(1);
          phase <= ~phase;
          if (cnt == LENW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    pattern_lane #(
      .WIDTH (WIDTH),
      .CH    (g)
    ) u_lane (
      .c     (c),
      .rn    (rn),
      .clr   (clr),
      .upd   ((state == RUN) && en[g]),
      .mode  (mode_q),
      .phase (phase),
      .q     (a[g])
    );
  end

endmodule
